// File: rtl/status_sequencer.sv
// Save/restore sequencer for a 16x1 status memory: walks addresses 0..15 to
// snapshot the status bits into snap_word, or to write a held word back.
module status_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        save_req,
    input  logic        restore_req,
    input  logic [15:0] restore_word,
    input  logic        st_din,
    output logic [3:0]  st_addr,
    output logic        st_we,
    output logic        st_dout,
    output logic [15:0] snap_word,
    output logic        busy,
    output logic        done
);

    localparam int unsigned W  = 16;
    localparam int unsigned AW = 4;
    localparam logic [AW-1:0] LAST = AW'(W - 1);

    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic [W-1:0]  hold, hold_nx;
    logic [W-1:0]  shadow, shadow_nx;
    logic [W-1:0]  snap_nx;
    logic [AW-1:0] addr_nx;
    logic          we_nx, dout_nx, busy_nx, done_nx;

    // State, datapath and registered outputs; outputs follow the next state so
    // they line up with the cycle the FSM is in and never see the request pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hold      <= '0;
            shadow    <= '0;
            snap_word <= '0;
            st_addr   <= '0;
            st_we     <= 1'b0;
            st_dout   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            hold      <= hold_nx;
            shadow    <= shadow_nx;
            snap_word <= snap_nx;
            st_addr   <= addr_nx;
            st_we     <= we_nx;
            st_dout   <= dout_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        hold_nx   = hold;
        shadow_nx = shadow;
        snap_nx   = snap_word;

        case (state)
            IDLE: begin
                if (save_req) begin
                    state_nx = SAVE;
                    cnt_nx   = '0;
                end else if (restore_req) begin
                    state_nx = RESTORE;
                    cnt_nx   = '0;
                    hold_nx  = restore_word;
                end
            end
            SAVE: begin
                shadow_nx[cnt] = st_din;
                cnt_nx         = cnt + AW'(1);
                if (cnt == LAST) begin
                    state_nx = DONE;
                    snap_nx  = shadow_nx;
                end
            end
            RESTORE: begin
                cnt_nx = cnt + AW'(1);
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
        we_nx   = (state_nx == RESTORE);
        addr_nx = (state_nx == SAVE || state_nx == RESTORE) ? cnt_nx : '0;
        dout_nx = we_nx & hold_nx[cnt_nx];
    end

endmodule

// File: tb/tb_status_sequencer.sv
// Bench for status_sequencer: a 16x1 status memory, an operation-timeline
// reference model, per-cycle output comparison, directed and random stimulus.
module tb_status_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        save_req, restore_req;
    logic [15:0] restore_word;
    logic        st_din;
    logic [3:0]  st_addr;
    logic        st_we, st_dout;
    logic [15:0] snap_word;
    logic        busy, done;

    status_sequencer dut (
        .clk(clk), .rst_n(rst_n), .save_req(save_req), .restore_req(restore_req),
        .restore_word(restore_word), .st_din(st_din), .st_addr(st_addr),
        .st_we(st_we), .st_dout(st_dout), .snap_word(snap_word),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Status memory with a bench-side preload port.
    logic [15:0] mem;
    logic        load_en;
    logic [15:0] load_val;
    assign st_din = mem[st_addr];
    always @(posedge clk) begin
        if (load_en) mem <= load_val;
        else if (st_we) mem[st_addr] <= st_dout;
    end

    // Reference model: an operation is a kind plus its age in cycles since acceptance.
    // Ages 0..15 are memory cycles on address=age, age 16 is the done cycle.
    int          op;          // 0 none, 1 save, 2 restore
    int          age;
    logic [15:0] hold_m, snap_pend, snap_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op <= 0; age <= 0; hold_m <= '0; snap_pend <= '0; snap_m <= '0;
        end else if (op == 0) begin
            if (save_req) begin
                op <= 1; age <= 0; snap_pend <= mem;
            end else if (restore_req) begin
                op <= 2; age <= 0; hold_m <= restore_word;
            end
        end else if (age == 16) begin
            op <= 0;
        end else begin
            age <= age + 1;
            if (op == 1 && age == 15) snap_m <= snap_pend;
        end
    end

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, we_cnt = 0, done_cnt = 0, done_prev = 0, done_last = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [23:0] act_v, exp_v;
    logic        e_busy, e_done, e_we, e_dout;
    logic [3:0]  e_addr;
    int          we0, done0;

    initial begin
        rst_n = 1'b0; save_req = 1'b0; restore_req = 1'b0; restore_word = '0;
        load_en = 1'b1; load_val = 16'hA5C3;

        // Per-cycle compare against the model plus activity counters.
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (rst_n) begin
                    e_busy = (op != 0);
                    e_done = (op != 0) && (age == 16);
                    e_we   = (op == 2) && (age < 16);
                    e_addr = (op != 0 && age < 16) ? 4'(age) : 4'd0;
                    e_dout = e_we ? hold_m[4'(age)] : 1'b0;
                    act_v  = {busy, done, st_we, st_addr, st_dout, snap_word};
                    exp_v  = {e_busy, e_done, e_we, e_addr, e_dout, snap_m};
                    check("outputs{busy,done,we,addr,dout,snap}", 32'(act_v), 32'(exp_v));
                    if (e_done && op == 2) check("restored_mem", 32'(mem), 32'(hold_m));
                    if (st_we) we_cnt++;
                    if (done) begin
                        done_cnt++; done_prev = done_last; done_last = cyc;
                    end
                end
            end
        join_none

        tick(2);
        load_en = 1'b0;
        check("reset_state", {busy, done, st_we, st_addr, snap_word}, 32'h0);
        rst_n = 1'b1;

        // Save of a preloaded pattern.
        we0 = we_cnt; done0 = done_cnt;
        save_req = 1'b1; tick(1); save_req = 1'b0;
        tick(15);
        check("save_not_done_early", 32'(done), 32'h0);
        tick(1);
        check("save_done_latency", 32'(done), 32'h1);
        tick(1);
        check("save_idle_after", 32'(busy), 32'h0);
        check("save_snap", 32'(snap_word), 32'hA5C3);
        check("save_no_write", 32'(we_cnt - we0), 32'd0);
        check("save_one_done", 32'(done_cnt - done0), 32'd1);

        // Restore with restore_word changing after acceptance, then save it back.
        we0 = we_cnt;
        restore_word = 16'h3C5A; restore_req = 1'b1; tick(1);
        restore_req = 1'b0; restore_word = 16'hFFFF;
        tick(17);
        check("restore_mem", 32'(mem), 32'h3C5A);
        check("restore_we_cycles", 32'(we_cnt - we0), 32'd16);
        save_req = 1'b1; tick(1); save_req = 1'b0; tick(17);
        check("resave_snap", 32'(snap_word), 32'h3C5A);

        // Both requests together: save wins.
        we0 = we_cnt;
        save_req = 1'b1; restore_req = 1'b1; tick(1);
        save_req = 1'b0; restore_req = 1'b0; tick(17);
        check("both_mem_unchanged", 32'(mem), 32'h3C5A);
        check("both_no_write", 32'(we_cnt - we0), 32'd0);

        // Restore request mid-save is dropped.
        we0 = we_cnt; done0 = done_cnt;
        save_req = 1'b1; tick(1); save_req = 1'b0; tick(7);
        restore_req = 1'b1; restore_word = 16'h0000; tick(1); restore_req = 1'b0;
        check("midsave_busy", 32'(busy), 32'h1);
        tick(9);
        check("midsave_one_done", 32'(done_cnt - done0), 32'd1);
        check("midsave_no_write", 32'(we_cnt - we0), 32'd0);
        tick(4);
        check("midsave_not_queued", 32'(busy), 32'h0);

        // Reset partway through a restore.
        load_en = 1'b1; load_val = 16'h0000; tick(1); load_en = 1'b0;
        restore_word = 16'hFFFF; restore_req = 1'b1; tick(1); restore_req = 1'b0;
        tick(5);
        rst_n = 1'b0; #1;
        check("rst_we_async", {st_we, busy, done}, 32'h0);
        tick(1); rst_n = 1'b1;
        check("rst_mem_partial", 32'(mem), 32'h001F);
        check("rst_snap_clear", 32'(snap_word), 32'h0);

        // Reset partway through a save publishes nothing.
        load_en = 1'b1; load_val = 16'hBEEF; tick(1); load_en = 1'b0;
        save_req = 1'b1; tick(1); save_req = 1'b0; tick(8);
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        tick(20);
        check("rst_save_snap", 32'(snap_word), 32'h0);

        // Held save_req: one operation every 18 cycles.
        done0 = done_cnt;
        save_req = 1'b1; tick(55);
        check("held_done_count", 32'(done_cnt - done0), 32'd3);
        check("held_done_spacing", 32'(done_last - done_prev), 32'd18);
        check("held_snap", 32'(snap_word), 32'hBEEF);
        save_req = 1'b0; tick(20);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            save_req     = ($urandom_range(0, 7) == 0);
            restore_req  = ($urandom_range(0, 5) == 0);
            restore_word = 16'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0; tick(1); rst_n = 1'b1;
            end else begin
                tick(1);
            end
        end
        save_req = 1'b0; restore_req = 1'b0;
        tick(20);
        check("final_idle", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
